fpga_top_mac_acc_16: RTL and testbench

- Downstream consumer of the 9-bit x 10-bit unsigned multiplier stage, which produces a 16-bit product. This block registers that product and accumulates a configurable number of products into one wide sum.
- Presents the sum on a valid/ready output, so it forms the multiply-accumulate tail of a CNN dot-product lane inside fpga_top.
- Multiply is inferred in stage 1 with the same unsigned 9x10 to 16 truncating semantics as the multiplier stage.

---
 rtl/fpga_top_mac_pkg.sv | 19 +
 rtl/fpga_top_mac_prod_reg.sv | 39 +++
 rtl/fpga_top_mac_acc_16.sv | 141 ++++++++++++++
 tb/tb_fpga_top_mac_acc_16.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/fpga_top_mac_pkg.sv
// rtl/fpga_top_mac_pkg.sv - shared types and constants for the multiply-accumulate tail
package fpga_top_mac_pkg;

    localparam int A_WIDTH_DEF   = 9;
    localparam int B_WIDTH_DEF   = 10;
    localparam int P_WIDTH_DEF   = 16;
    localparam int ACC_WIDTH_DEF = 24;
    localparam int LEN_WIDTH_DEF = 8;

    // Saturation value; the accumulator takes the low ACC_WIDTH bits (all ones)
    localparam logic [63:0] ACC_MAX = '1;

    typedef enum logic [1:0] {
        ACC   = 2'd0,
        FLUSH = 2'd1,
        HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/fpga_top_mac_prod_reg.sv
// rtl/fpga_top_mac_prod_reg.sv - stage-1 registered truncating multiply with valid/first/last sideband
module fpga_top_mac_prod_reg
    import fpga_top_mac_pkg::*;
#(
    parameter int A_WIDTH = A_WIDTH_DEF,
    parameter int B_WIDTH = B_WIDTH_DEF,
    parameter int P_WIDTH = P_WIDTH_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               accept,
    input  logic               first,
    input  logic               last,
    input  logic [A_WIDTH-1:0] a,
    input  logic [B_WIDTH-1:0] b,
    output logic [P_WIDTH-1:0] p_q,
    output logic               p_v,
    output logic               p_first,
    output logic               p_last
);

    // Register the product modulo 2^P_WIDTH together with its group position
    always_ff @(posedge clk) begin
        if (rst) begin
            p_q     <= '0;
            p_v     <= 1'b0;
            p_first <= 1'b0;
            p_last  <= 1'b0;
        end else if (accept) begin
            p_q     <= P_WIDTH'(a * b);
            p_v     <= 1'b1;
            p_first <= first;
            p_last  <= last;
        end else begin
            p_v     <= 1'b0;
        end
    end

endmodule

// File: rtl/fpga_top_mac_acc_16.sv
// rtl/fpga_top_mac_acc_16.sv - multiply-accumulate tail with saturating sum on a valid/ready output
module fpga_top_mac_acc_16
    import fpga_top_mac_pkg::*;
#(
    parameter int A_WIDTH   = A_WIDTH_DEF,
    parameter int B_WIDTH   = B_WIDTH_DEF,
    parameter int P_WIDTH   = P_WIDTH_DEF,
    parameter int ACC_WIDTH = ACC_WIDTH_DEF,
    parameter int LEN_WIDTH = LEN_WIDTH_DEF
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst,
    input  logic [LEN_WIDTH-1:0] cfg_len,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [A_WIDTH-1:0]   in_a,
    input  logic [B_WIDTH-1:0]   in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_data,
    output logic                 out_sat
);

    localparam logic [ACC_WIDTH-1:0] ACC_ONES = ACC_MAX[ACC_WIDTH-1:0];

    state_t                 state;
    state_t                 state_n;
    logic                   first;
    logic [LEN_WIDTH-1:0]   count;
    logic [LEN_WIDTH-1:0]   len_q;
    logic [LEN_WIDTH-1:0]   cfg_len_eff;
    logic [LEN_WIDTH-1:0]   len_eff;
    logic [LEN_WIDTH-1:0]   count_inc;
    logic                   accept;
    logic                   last_beat;

    logic [P_WIDTH-1:0]     p_q;
    logic                   p_v;
    logic                   p_first;
    logic                   p_last;

    logic [ACC_WIDTH-1:0]   acc;
    logic                   sat_flag;
    logic [ACC_WIDTH-1:0]   acc_base;
    logic [ACC_WIDTH:0]     sum;
    logic                   sat_hit;
    logic [ACC_WIDTH-1:0]   acc_next;
    logic                   sat_next;

    assign in_ready    = (state == ACC);
    assign out_valid   = (state == HOLD);
    assign accept      = in_valid && in_ready;
    // A zero length would never close a group, so it behaves as a single product
    assign cfg_len_eff = (cfg_len == '0) ? LEN_WIDTH'(1) : cfg_len;
    assign len_eff     = first ? cfg_len_eff : len_q;
    assign count_inc   = count + LEN_WIDTH'(1);
    assign last_beat   = accept && (count_inc == len_eff);

    // Group bookkeeping: latch the length on the opening beat and count beats
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            first <= 1'b1;
            count <= '0;
            len_q <= '0;
        end else if (accept) begin
            if (first) begin
                len_q <= cfg_len_eff;
            end
            if (last_beat) begin
                count <= '0;
                first <= 1'b1;
            end else begin
                count <= count_inc;
                first <= 1'b0;
            end
        end
    end

    fpga_top_mac_prod_reg #(
        .A_WIDTH (A_WIDTH),
        .B_WIDTH (B_WIDTH),
        .P_WIDTH (P_WIDTH)
    ) u_prod_reg (
        .clk     (ap_clk),
        .rst     (ap_rst),
        .accept  (accept),
        .first   (first),
        .last    (last_beat),
        .a       (in_a),
        .b       (in_b),
        .p_q     (p_q),
        .p_v     (p_v),
        .p_first (p_first),
        .p_last  (p_last)
    );

    // One spare bit on the sum exposes overflow for saturation
    assign acc_base = p_first ? '0 : acc;
    assign sum      = {1'b0, acc_base} + (ACC_WIDTH + 1)'(p_q);
    assign sat_hit  = sum[ACC_WIDTH];
    assign acc_next = sat_hit ? ACC_ONES : sum[ACC_WIDTH-1:0];
    assign sat_next = (p_first ? 1'b0 : sat_flag) | sat_hit;

    // Stage 2: absorb each product and publish the sum on the group's last product
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            acc      <= '0;
            sat_flag <= 1'b0;
            out_data <= '0;
            out_sat  <= 1'b0;
        end else if (p_v) begin
            acc      <= acc_next;
            sat_flag <= sat_next;
            if (p_last) begin
                out_data <= acc_next;
                out_sat  <= sat_next;
            end
        end
    end

    // State register
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state <= ACC;
        end else begin
            state <= state_n;
        end
    end

    // Next state: stop intake after the last beat until the result is taken
    always_comb begin
        state_n = state;
        case (state)
            ACC:     if (last_beat)      state_n = FLUSH;
            FLUSH:   if (p_v && p_last)  state_n = HOLD;
            HOLD:    if (out_ready)      state_n = ACC;
            default:                     state_n = ACC;
        endcase
    end

endmodule

// File: tb/tb_fpga_top_mac_acc_16.sv
// tb/tb_fpga_top_mac_acc_16.sv - scoreboard bench for the multiply-accumulate tail
module tb_fpga_top_mac_acc_16;

    localparam int ACC_W = 20;

    typedef struct packed {
        logic [ACC_W-1:0] data;
        logic             sat;
    } exp_t;

    logic             ap_clk = 1'b0;
    logic             ap_rst = 1'b1;
    logic [7:0]       cfg_len = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [8:0]       in_a = '0;
    logic [9:0]       in_b = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [ACC_W-1:0] out_data;
    logic             out_sat;

    exp_t sb_q[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;

    fpga_top_mac_acc_16 #(
        .ACC_WIDTH (ACC_W)
    ) dut (
        .ap_clk    (ap_clk),
        .ap_rst    (ap_rst),
        .cfg_len   (cfg_len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: compare every handshaked result against the scoreboard head
    always @(negedge ap_clk) begin
        if (!ap_rst && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got %0d expected none", out_data);
            end else begin
                mon_e = sb_q.pop_front();
                check("result_data", 32'(out_data), 32'(mon_e.data));
                check("result_sat", 32'(out_sat), 32'(mon_e.sat));
            end
        end
    end

    task automatic push_exp(input int data, input logic sat);
        exp_t e;
        e.data = ACC_W'(data);
        e.sat  = sat;
        sb_q.push_back(e);
    endtask

    // Called #1 after a rising edge; returns #1 after the accepting edge
    task automatic send_beat(input int a, input int b, input int len);
        int n;
        n = 0;
        cfg_len  = 8'(len);
        in_a     = 9'(a);
        in_b     = 10'(b);
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(posedge ap_clk);
            #1;
            n++;
        end
        if (!in_ready) check("accept_timeout", 32'(in_ready), 32'd1);
        @(posedge ap_clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 40) begin
            @(posedge ap_clk);
            #1;
            n++;
        end
        check("drain", 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        repeat (2) @(posedge ap_clk);
        #1;
        ap_rst = 1'b0;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_sat", 32'(out_sat), 32'd0);

        // Basic group with latency check
        push_exp(68, 1'b0);
        send_beat(2, 3, 3);
        send_beat(4, 5, 3);
        send_beat(6, 7, 3);
        check("lat_t1_valid", 32'(out_valid), 32'd0);
        @(posedge ap_clk);
        #1;
        check("lat_t2_valid", 32'(out_valid), 32'd1);
        check("lat_t2_in_ready", 32'(in_ready), 32'd0);
        @(posedge ap_clk);
        #1;
        check("post_hs_valid", 32'(out_valid), 32'd0);
        check("post_hs_in_ready", 32'(in_ready), 32'd1);
        wait_drain();

        // Truncation of the product to 16 bits
        push_exp(64001, 1'b0);
        send_beat(511, 1023, 1);
        wait_drain();

        // Zero length, then a length change inside a group
        push_exp(12, 1'b0);
        send_beat(3, 4, 0);
        push_exp(5, 1'b0);
        send_beat(1, 1, 2);
        send_beat(2, 2, 5);
        wait_drain();

        // Saturation, then a clean group clears the flag
        push_exp(1048575, 1'b1);
        for (int i = 0; i < 17; i++) send_beat(511, 1023, 17);
        push_exp(1, 1'b0);
        send_beat(1, 1, 1);
        wait_drain();

        // Backpressure: result held, intake blocked, stray beats ignored
        out_ready = 1'b0;
        push_exp(25, 1'b0);
        send_beat(5, 5, 1);
        n = 0;
        while (!out_valid && n < 10) begin
            @(posedge ap_clk);
            #1;
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_a     = 9'd7;
            in_b     = 10'd7;
            cfg_len  = 8'd1;
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_out_data", 32'(out_data), 32'd25);
            check("bp_out_sat", 32'(out_sat), 32'd0);
            @(posedge ap_clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge ap_clk);
        #1;
        check("bp_release_in_ready", 32'(in_ready), 32'd1);
        check("bp_release_valid", 32'(out_valid), 32'd0);
        push_exp(6, 1'b0);
        send_beat(2, 3, 1);
        wait_drain();

        // Reset in the middle of a group discards it
        send_beat(10, 10, 4);
        send_beat(10, 10, 4);
        ap_rst = 1'b1;
        @(posedge ap_clk);
        #1;
        ap_rst = 1'b0;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        push_exp(1, 1'b0);
        send_beat(1, 1, 1);
        wait_drain();

        repeat (3) @(posedge ap_clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
